mul_unit: RTL
=============

MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 The module SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-002 Port `clk`, input, 1 bit: rising-edge clock for all state.
REQ-003 Port `rst_n`, input, 1 bit: asynchronous active-low reset.
REQ-004 Port `enable`, input, 1 bit: when low, the FSM returns to IDLE on the next edge.
REQ-005 Port `start`, input, 1 bit: sampled only in IDLE; starts an operation.
REQ-006 Port `in_bus`, input, 8 bits: operand input, multiplier first, then multiplicand.
REQ-007 Port `out_bus`, output, 8 bits: product byte, valid only while `out_valid` is high, otherwise 0.
REQ-008 Port `out_valid`, output, 1 bit: high during OUT_HI and OUT_LO.
REQ-009 Port `busy`, output, 1 bit: high in every state except IDLE.
REQ-010 Port `done`, output, 1 bit: one-cycle pulse in OUT_LO.

Function
REQ-011 The FSM SHALL have the states IDLE, LOAD_Q, LOAD_M, ITER, OUT_HI and OUT_LO.
REQ-012 The FSM SHALL make these transitions:
- IDLE to LOAD_Q when start=1, otherwise stay in IDLE.
- LOAD_Q to LOAD_M.
- LOAD_M to ITER.
- ITER to OUT_HI when cnt=7, otherwise stay in ITER.
- OUT_HI to OUT_LO.
- OUT_LO to IDLE.
REQ-013 In LOAD_Q: Q<=in_bus, A<=0, q_m1<=0, cnt<=0.
REQ-014 In LOAD_M: M<=in_bus.
REQ-015 Each ITER cycle SHALL do exactly one add/subtract plus one shift, then cnt<=cnt+1; there are exactly 8 ITER cycles.
REQ-016 OUT_HI SHALL drive out_bus=A (product[15:8]); OUT_LO SHALL drive out_bus=Q (product[7:0]).
REQ-017 Latency: with start sampled at edge 0, Q loads at edge 1, M at edge 2, ITER covers edges 3-10, OUT_HI is cycle 11, OUT_LO/done is cycle 12, and the FSM is in IDLE at cycle 13.
REQ-018 The FSM SHALL accept a new start in the cycle after OUT_LO; there are no back-to-back bubbles beyond that.
REQ-019 start asserted while busy SHALL be ignored, with no restart and no queueing.
REQ-020 enable=0 in any state SHALL move the FSM to IDLE on the next edge. The partial result is discarded, no done pulse is produced, and the A/Q/M registers keep their values but are never output.
REQ-021 enable=0 together with start=1 in IDLE SHALL leave the FSM in IDLE.
REQ-022 All arithmetic SHALL be modulo 2^8 in A (plus the carry bit in unsigned mode); the product is the full 16 bits with no overflow flag.

Reset
REQ-023 While rst_n=0, the module SHALL hold: state=IDLE, A=Q=M=0, q_m1=0, cnt=0, carry=0, out_bus=0, out_valid=0, busy=0, done=0.
REQ-024 Reset asserted mid-operation SHALL abort immediately (asynchronously) with no done pulse; after release, the first possible start is at the next edge.

Configuration
REQ-025 The macro `MUL_SIGNED_EN` SHALL select the multiplication mode.
REQ-026 With `MUL_SIGNED_EN` defined: two's-complement radix-2 Booth.
- {Q[0],q_m1}=01: A<=A+M.
- {Q[0],q_m1}=10: A<=A-M.
- 00 and 11: no add/subtract.
- Then arithmetic shift right of {A,Q,q_m1}.
REQ-027 Without `MUL_SIGNED_EN`: unsigned shift-add.
- Q[0]=1: {carry,A}<=A+M.
- Then logical shift right of {carry,A,Q}.
- q_m1 is unused and held at 0.
REQ-028 The port list and the cycle timing SHALL be identical in both modes.

Structure
REQ-029 The shared package `alu_pkg` SHALL hold the state enumeration, the constant DATA_W=8, the constant ITER_N=8 and the counter width CNT_W=3.
REQ-030 Next-state logic and the per-state control strobes (load_q, load_m, iter_en, out_hi, out_lo) SHALL live in the sub-module `mul_logic`, which is purely combinational.
REQ-031 The state, counter and datapath registers SHALL live in `mul_unit`.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Either mode: in_bus 7 then 6 → out_bus 0x00 at cycle 11 and 0x2A at cycle 12; done pulses at cycle 12.
- Signed: -3 (0xFD) × 5 → 0xFF then 0xF1 (−15).
- Signed: 0x80 × 0x80 → 0x40 then 0x00 (+16384).
- Unsigned: 0xFF × 0xFF → 0xFE then 0x01.
- enable dropped at cycle 6 → IDLE at cycle 7, no out_valid, no done; a following 2×3 run → 0x00 then 0x06.
- start pulsed again during ITER → ignored, result unchanged; rst_n low at cycle 8 → all outputs 0 at once, busy=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential multiplier (mul_unit / mul_logic).
// Build option: define MUL_SIGNED_EN for Booth signed mode; default is unsigned shift-add.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int ITER_N = 8;
    localparam int CNT_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_Q,
        LOAD_M,
        ITER,
        OUT_HI,
        OUT_LO
    } state_e;

    // Counter value seen in the last ITER cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_N - 1);

endpackage : alu_pkg

// File: rtl/mul_logic.sv
// Combinational next-state and per-state control strobes for mul_unit.
// Identical in both MUL_SIGNED_EN modes: only the datapath differs.
module mul_logic
    import alu_pkg::*;
(
    input  state_e             i_state,
    input  logic               i_enable,
    input  logic               i_start,
    input  logic [CNT_W-1:0]   i_cnt,
    output state_e             o_next_state,
    output logic               o_load_q,
    output logic               o_load_m,
    output logic               o_iter_en,
    output logic               o_out_hi,
    output logic               o_out_lo,
    output logic               o_busy
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        o_next_state = i_state;
        o_load_q     = 1'b0;
        o_load_m     = 1'b0;
        o_iter_en    = 1'b0;
        o_out_hi     = 1'b0;
        o_out_lo     = 1'b0;

        case (i_state)
            IDLE:   if (i_start) o_next_state = LOAD_Q;
            LOAD_Q: begin
                o_load_q     = 1'b1;
                o_next_state = LOAD_M;
            end
            LOAD_M: begin
                o_load_m     = 1'b1;
                o_next_state = ITER;
            end
            ITER: begin
                o_iter_en = 1'b1;
                if (i_cnt == CNT_LAST) o_next_state = OUT_HI;
            end
            OUT_HI: begin
                o_out_hi     = 1'b1;
                o_next_state = OUT_LO;
            end
            OUT_LO: begin
                o_out_lo     = 1'b1;
                o_next_state = IDLE;
            end
            default: o_next_state = IDLE;
        endcase

        // Dropping enable aborts from any state and freezes the datapath registers.
        if (!i_enable) begin
            o_next_state = IDLE;
            o_load_q     = 1'b0;
            o_load_m     = 1'b0;
            o_iter_en    = 1'b0;
        end
    end

    assign o_busy = (i_state != IDLE);

endmodule : mul_logic

// File: rtl/mul_unit.sv
// 8x8 -> 16 sequential multiplier: product streamed as high byte then low byte.
// Build option: MUL_SIGNED_EN selects radix-2 Booth (signed); otherwise unsigned shift-add.
module mul_unit
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              start,
    input  logic [DATA_W-1:0] in_bus,
    output logic [DATA_W-1:0] out_bus,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    state_e             r_state;
    state_e             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_q;
    logic [DATA_W-1:0]  r_m;
    logic [DATA_W:0]    w_sum;
    logic               w_load_q;
    logic               w_load_m;
    logic               w_iter_en;
    logic               w_out_hi;
    logic               w_out_lo;

`ifdef MUL_SIGNED_EN
    logic               r_q_m1;

    // The add/sub runs one bit wide so the shift brings in the true sign;
    // this keeps (-128)*(-128) exact while A itself stays 8 bits.
    always_comb begin
        unique case ({r_q[0], r_q_m1})
            2'b01:   w_sum = {r_a[DATA_W-1], r_a} + {r_m[DATA_W-1], r_m};
            2'b10:   w_sum = {r_a[DATA_W-1], r_a} - {r_m[DATA_W-1], r_m};
            default: w_sum = {r_a[DATA_W-1], r_a};
        endcase
    end
`else
    logic               r_carry;

    assign w_sum = r_q[0] ? ({1'b0, r_a} + {1'b0, r_m}) : {r_carry, r_a};
`endif

    mul_logic u_logic (
        .i_state      (r_state),
        .i_enable     (enable),
        .i_start      (start),
        .i_cnt        (r_cnt),
        .o_next_state (w_next_state),
        .o_load_q     (w_load_q),
        .o_load_m     (w_load_m),
        .o_iter_en    (w_iter_en),
        .o_out_hi     (w_out_hi),
        .o_out_lo     (w_out_lo),
        .o_busy       (busy)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_q   <= '0;
            r_m   <= '0;
            r_cnt <= '0;
`ifdef MUL_SIGNED_EN
            r_q_m1 <= 1'b0;
`else
            r_carry <= 1'b0;
`endif
        end else if (w_load_q) begin
            r_q   <= in_bus;
            r_a   <= '0;
            r_cnt <= '0;
`ifdef MUL_SIGNED_EN
            r_q_m1 <= 1'b0;
`else
            r_carry <= 1'b0;
`endif
        end else if (w_load_m) begin
            r_m <= in_bus;
        end else if (w_iter_en) begin
            // One add/sub and one right shift of {A,Q} per cycle.
            r_a   <= w_sum[DATA_W:1];
            r_q   <= {w_sum[0], r_q[DATA_W-1:1]};
            r_cnt <= r_cnt + CNT_W'(1);
`ifdef MUL_SIGNED_EN
            r_q_m1 <= r_q[0];
`else
            r_carry <= 1'b0;
`endif
        end
    end

    assign out_valid = w_out_hi | w_out_lo;
    assign done      = w_out_lo;
    assign out_bus   = w_out_hi ? r_a : (w_out_lo ? r_q : '0);

endmodule : mul_unit
